// File: rtl/genius_lfsr_prng_pkg.sv
// ============================================================================
// Module      : typedefs (package)
// Description : Shared constants, color encoding and seed helper for the
//               Genius game pseudo-random source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package typedefs;

    localparam int          LFSR_WIDTH        = 4;
    localparam logic [3:0]  LFSR_TAPS         = 4'b1100;
    localparam logic [3:0]  LFSR_DEFAULT_SEED = 4'b0001;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } color_t;

    // An all-zero state would lock the LFSR, so it is replaced on load.
    function automatic logic [LFSR_WIDTH-1:0] seed_sanitize(
        input logic [LFSR_WIDTH-1:0] seed,
        input logic [LFSR_WIDTH-1:0] fallback
    );
        return (seed == '0) ? fallback : seed;
    endfunction

endpackage

`default_nettype wire

// File: rtl/genius_lfsr_prng_if.sv
// ============================================================================
// Module      : signals_interface
// Description : Signal bundle between the game controller and the LFSR source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signals_interface;
    import typedefs::*;

    logic [LFSR_WIDTH-1:0] seed;
    logic                  seed_load;
    logic [1:0]            color_bits;
    logic                  random_out;

    modport master (
        output seed,
        output seed_load,
        input  color_bits,
        input  random_out
    );

    modport slave (
        input  seed,
        input  seed_load,
        output color_bits,
        output random_out
    );

endinterface

`default_nettype wire

// File: rtl/genius_lfsr_prng.sv
// ============================================================================
// Module      : genius_lfsr_prng
// Description : Free-running 4-bit Fibonacci LFSR (x^4 + x^3 + 1) with
//               reseed, supplying a color index and a random bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module genius_lfsr_prng
    import typedefs::*;
#(
    parameter int                    LFSR_WIDTH   = typedefs::LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] TAPS         = LFSR_TAPS,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  wire logic         clk,
    input  wire logic         rst_,
    signals_interface.slave   sb
);

    logic [LFSR_WIDTH-1:0] r_state;
    logic [LFSR_WIDTH-1:0] w_next;
    logic [LFSR_WIDTH-1:0] w_load_val;
    logic                  w_fb;
    color_t                w_color;

    always_comb begin
        w_fb       = ^(r_state & TAPS);
        w_load_val = seed_sanitize(sb.seed, DEFAULT_SEED);
        w_next     = {r_state[LFSR_WIDTH-2:0], w_fb};
        if (sb.seed_load) begin
            w_next = w_load_val;
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state <= DEFAULT_SEED;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode straight from the register so seed inputs never reach them.
    assign w_color       = color_t'(r_state[1:0]);
    assign sb.color_bits = w_color;
    assign sb.random_out = r_state[LFSR_WIDTH-1];

    a_state_nonzero : assert property (@(posedge clk) r_state != '0)
        else $error("lfsr state reached zero");

    a_load_one_cycle : assert property (
        @(posedge clk) disable iff (rst_)
        sb.seed_load |=> (r_state == $past(w_load_val))
    ) else $error("seed load did not take effect in one cycle");

    a_color_matches : assert property (@(posedge clk) sb.color_bits == r_state[1:0])
        else $error("color_bits does not track state");

endmodule

`default_nettype wire

// File: tb/tb_genius_lfsr_prng.sv
// ============================================================================
// Module      : tb_genius_lfsr_prng
// Description : Directed self-checking bench for genius_lfsr_prng.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_genius_lfsr_prng;

    logic clk;
    logic rst_;
    int   n_checks;
    int   n_errors;

    signals_interface sif ();

    genius_lfsr_prng dut (
        .clk  (clk),
        .rst_ (rst_),
        .sb   (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // State is checked both internally and through the two decoded outputs.
    task automatic check_state(input string tag, input logic [3:0] exp);
        check_value({tag, " state"}, dut.r_state, exp);
        check_value({tag, " outputs"}, {1'b0, sif.random_out, sif.color_bits},
                    {1'b0, exp[3], exp[1:0]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq [0:14];

    initial begin
        n_checks = 0;
        n_errors = 0;
        seq = '{4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100,
                4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010};

        // Reset held for two cycles
        sif.seed      = 4'b0000;
        sif.seed_load = 1'b0;
        rst_          = 1'b1;
        #1;
        check_state("reset_imm", 4'b0001);
        tick();
        check_state("reset_hold1", 4'b0001);
        tick();
        check_state("reset_hold2", 4'b0001);
        rst_ = 1'b0;
        check_state("post_reset", 4'b0001);
        tick();
        check_state("post_reset_step1", 4'b0010);
        tick();
        check_state("post_reset_step2", 4'b0100);

        // Load 1010 then walk the full period
        sif.seed      = 4'b1010;
        sif.seed_load = 1'b1;
        tick();
        sif.seed_load = 1'b0;
        check_state("load_1010", 4'b1010);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_state($sformatf("seq_%0d", i), seq[i]);
        end

        // 16 free-running cycles then reseed with 0101
        for (int i = 0; i < 16; i++) tick();
        check_state("free16", 4'b0101);
        sif.seed      = 4'b0101;
        sif.seed_load = 1'b1;
        tick();
        sif.seed_load = 1'b0;
        check_state("reseed_0101", 4'b0101);
        tick();
        check_state("reseed_step1", 4'b1011);
        tick();
        check_state("reseed_step2", 4'b0111);
        tick();
        check_state("reseed_step3", 4'b1111);

        // Zero seed is replaced by the default
        sif.seed      = 4'b0000;
        sif.seed_load = 1'b1;
        tick();
        sif.seed_load = 1'b0;
        check_state("zero_seed", 4'b0001);
        tick();
        check_state("zero_seed_step", 4'b0010);

        // Held load for five cycles
        sif.seed      = 4'b0110;
        sif.seed_load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("held_%0d", i), 4'b0110);
        end
        sif.seed_load = 1'b0;
        tick();
        check_state("held_release", 4'b1101);

        // Seed changing while load held
        sif.seed      = 4'b0110;
        sif.seed_load = 1'b1;
        tick();
        sif.seed      = 4'b1001;
        tick();
        check_state("held_seed_change", 4'b1001);
        sif.seed_load = 1'b0;
        tick();
        check_state("held_change_step", 4'b0011);

        // Asynchronous reset between edges while state is 1111
        sif.seed      = 4'b0111;
        sif.seed_load = 1'b1;
        tick();
        sif.seed_load = 1'b0;
        tick();
        check_state("pre_async", 4'b1111);
        #2;
        rst_ = 1'b1;
        #1;
        check_state("async_reset", 4'b0001);
        #1;
        rst_ = 1'b0;
        tick();
        check_state("async_release_step", 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
